// File: rtl/router_sync_ctrl.sv
// Write-side controller for the 1x3 router: latches the destination,
// steers FIFO writes, flags valid ports and times out stalled readers.
module router_sync_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       detect_add,
  input  logic [1:0] din,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_rst_0,
  output logic       soft_rst_1,
  output logic       soft_rst_2
);

  localparam logic [1:0]       NO_PORT = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [1:0] addr_q;
  logic [1:0] addr_d;

  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;
  logic [2:0]            soft_q;
  logic [2:0]            soft_d;

  logic [2:0] rd_v;
  logic [2:0] empty_v;
  logic [2:0] full_v;
  logic [2:0] sel;
  logic       abort;

  assign rd_v    = {read_enb_2, read_enb_1, read_enb_0};
  assign empty_v = {empty_2, empty_1, empty_0};
  assign full_v  = {full_2, full_1, full_0};

  always_comb begin
    sel = 3'b000;
    unique case (addr_q)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
  end

  // A timeout on the port currently being written aborts the packet.
  assign abort = |(sel & soft_q);

  always_comb begin
    addr_d = addr_q;
    if (detect_add) begin
      addr_d = din;
    end else if (abort) begin
      addr_d = NO_PORT;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    soft_d = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (empty_v[i] || rd_v[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]  = '0;
        soft_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= NO_PORT;
      cnt_q  <= '0;
      soft_q <= 3'b000;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      soft_q <= soft_d;
    end
  end

  assign write_enb = write_enb_reg ? sel : 3'b000;
  assign fifo_full = |(sel & full_v);

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

  assign soft_rst_0 = soft_q[0];
  assign soft_rst_1 = soft_q[1];
  assign soft_rst_2 = soft_q[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Directed bench for router_sync_ctrl: steering, full flag,
// valid flags, timeout pulses, abort and reset behaviour.
module tb_router_sync_ctrl;

  logic       clk;
  logic       rst;
  logic       detect_add;
  logic [1:0] din;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;

  int n_checks;
  int n_fail;
  int pulses;

  router_sync_ctrl #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .detect_add    (detect_add),
    .din           (din),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_rst_0    (soft_rst_0),
    .soft_rst_1    (soft_rst_1),
    .soft_rst_2    (soft_rst_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    detect_add = 1'b0;
    din = 2'b00;
    write_enb_reg = 1'b0;
    {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
    {empty_2, empty_1, empty_0} = 3'b111;
    {full_2, full_1, full_0} = 3'b000;

    // T1 reset
    step(2);
    check("rst_wen", write_enb, 3'b000);
    check("rst_full", fifo_full, 1'b0);
    check("rst_soft", {soft_rst_2, soft_rst_1, soft_rst_0}, 3'b000);
    check("rst_vld", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);
    write_enb_reg = 1'b1;
    full_0 = 1'b1;
    #1;
    check("rst_wen_req", write_enb, 3'b000);
    check("rst_full_req", fifo_full, 1'b0);
    write_enb_reg = 1'b0;
    full_0 = 1'b0;

    // T2 latch 01 and steer
    rst = 1'b0;
    detect_add = 1'b1;
    din = 2'b01;
    step(1);
    detect_add = 1'b0;
    write_enb_reg = 1'b1;
    full_1 = 1'b1;
    #1;
    check("t2_wen", write_enb, 3'b010);
    check("t2_full", fifo_full, 1'b1);
    full_1 = 1'b0;
    full_0 = 1'b1;
    #1;
    check("t2_full_other", fifo_full, 1'b0);
    full_0 = 1'b0;
    detect_add = 1'b1;
    din = 2'b00;
    #1;
    check("t2_old_addr", write_enb, 3'b010);
    step(1);
    detect_add = 1'b0;
    #1;
    check("t2_new_addr", write_enb, 3'b001);
    write_enb_reg = 1'b0;
    #1;
    check("t2_no_req", write_enb, 3'b000);
    empty_1 = 1'b0;
    #1;
    check("vld_1", {vld_out_2, vld_out_1, vld_out_0}, 3'b010);
    empty_1 = 1'b1;
    step(1);

    // T3 port-2 stall; value after posedge c is cycle c+1
    empty_2 = 1'b0;
    read_enb_2 = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 61; c++) begin
      step(1);
      if (soft_rst_2) pulses++;
      if (c + 1 == 30) check("t3_c30", soft_rst_2, 1'b0);
      if (c + 1 == 31) check("t3_c31", soft_rst_2, 1'b1);
      if (c + 1 == 32) check("t3_c32", soft_rst_2, 1'b0);
      if (c + 1 == 61) check("t3_c61", soft_rst_2, 1'b1);
      if (c + 1 == 31) check("t3_indep", {soft_rst_1, soft_rst_0}, 2'b00);
    end
    check("t3_pulses", pulses, 2);
    check("t3_addr_kept", dut.write_enb_reg ? 3'b111 : 3'b000, 3'b000);
    empty_2 = 1'b1;
    step(1);

    // T4 read at cycle 29 restarts the count
    empty_2 = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 61; c++) begin
      read_enb_2 = (c == 29);
      step(1);
      if (soft_rst_2) pulses++;
      if (c + 1 == 31) check("t4_c31", soft_rst_2, 1'b0);
      if (c + 1 == 59) check("t4_c59", soft_rst_2, 1'b0);
      if (c + 1 == 60) check("t4_c60", soft_rst_2, 1'b1);
    end
    read_enb_2 = 1'b0;
    check("t4_pulses", pulses, 1);
    empty_2 = 1'b1;
    step(1);

    // T5 no-port address
    detect_add = 1'b1;
    din = 2'b11;
    step(1);
    detect_add = 1'b0;
    write_enb_reg = 1'b1;
    {full_2, full_1, full_0} = 3'b111;
    #1;
    check("t5_wen", write_enb, 3'b000);
    check("t5_full", fifo_full, 1'b0);
    {full_2, full_1, full_0} = 3'b000;
    write_enb_reg = 1'b0;

    // T6 timeout on the addressed port aborts it
    detect_add = 1'b1;
    din = 2'b00;
    step(1);
    detect_add = 1'b0;
    empty_0 = 1'b0;
    step(30);
    check("t6_pulse", soft_rst_0, 1'b1);
    write_enb_reg = 1'b1;
    #1;
    check("t6_before", write_enb, 3'b001);
    step(1);
    check("t6_abort", write_enb, 3'b000);
    check("t6_pulse_end", soft_rst_0, 1'b0);
    empty_0 = 1'b1;
    step(1);
    detect_add = 1'b1;
    din = 2'b00;
    step(1);
    detect_add = 1'b0;
    empty_0 = 1'b0;
    step(30);
    check("t6_pulse2", soft_rst_0, 1'b1);
    detect_add = 1'b1;
    din = 2'b10;
    step(1);
    detect_add = 1'b0;
    #1;
    check("t6_detect_wins", write_enb, 3'b100);
    write_enb_reg = 1'b0;
    empty_0 = 1'b1;
    step(1);

    // reset mid-count discards the partial count
    empty_1 = 1'b0;
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_wen", write_enb, 3'b000);
    step(29);
    check("mid_rst_c29", soft_rst_1, 1'b0);
    step(1);
    check("mid_rst_c30", soft_rst_1, 1'b1);
    step(1);
    check("mid_rst_c31", soft_rst_1, 1'b0);
    empty_1 = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
